// File: rtl/inv_mixcol_seq.sv
// Column-serial (Inv)MixColumns engine: one shared GF(2^8) column unit steps
// over columns 0..3 of a latched AES state, result held on a valid/ready output.
module inv_mixcol_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_i,
  input  logic         mode_i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_o,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_q;
  state_t       state_d;
  logic [1:0]   col_q;
  logic         mode_q;
  logic [127:0] src_q;
  logic [127:0] res_q;

  logic [31:0]  col_in;
  logic [31:0]  col_out;
  logic [7:0]   a0, a1, a2, a3;
  logic [7:0]   b0, b1, b2, b3;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul02(input logic [7:0] x);
    return xtime(x);
  endfunction

  function automatic logic [7:0] mul03(input logic [7:0] x);
    return xtime(x) ^ x;
  endfunction

  function automatic logic [7:0] mul09(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ x;
  endfunction

  function automatic logic [7:0] mul0b(input logic [7:0] x);
    return xtime(xtime(xtime(x)) ^ x) ^ x;
  endfunction

  function automatic logic [7:0] mul0d(input logic [7:0] x);
    return xtime(xtime(xtime(x) ^ x)) ^ x;
  endfunction

  function automatic logic [7:0] mul0e(input logic [7:0] x);
    return xtime(xtime(xtime(x) ^ x) ^ x);
  endfunction

  // Column 0 occupies the most significant 32 bits of the state.
  always_comb begin
    col_in = 32'h0;
    case (col_q)
      2'd0:    col_in = src_q[127:96];
      2'd1:    col_in = src_q[95:64];
      2'd2:    col_in = src_q[63:32];
      default: col_in = src_q[31:0];
    endcase
  end

  assign {a0, a1, a2, a3} = col_in;

  always_comb begin
    b0 = 8'h00;
    b1 = 8'h00;
    b2 = 8'h00;
    b3 = 8'h00;
    if (mode_q) begin
      b0 = mul02(a0) ^ mul03(a1) ^ a2 ^ a3;
      b1 = mul02(a1) ^ mul03(a2) ^ a3 ^ a0;
      b2 = mul02(a2) ^ mul03(a3) ^ a0 ^ a1;
      b3 = mul02(a3) ^ mul03(a0) ^ a1 ^ a2;
    end else begin
      b0 = mul0e(a0) ^ mul0b(a1) ^ mul0d(a2) ^ mul09(a3);
      b1 = mul0e(a1) ^ mul0b(a2) ^ mul0d(a3) ^ mul09(a0);
      b2 = mul0e(a2) ^ mul0b(a3) ^ mul0d(a0) ^ mul09(a1);
      b3 = mul0e(a3) ^ mul0b(a0) ^ mul0d(a1) ^ mul09(a2);
    end
  end

  assign col_out = {b0, b1, b2, b3};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (col_q == 2'd3) begin
          state_d = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Unwritten result columns keep their old contents until overwritten in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q  <= 2'd0;
      mode_q <= 1'b0;
      src_q  <= 128'h0;
      res_q  <= 128'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            src_q  <= state_i;
            mode_q <= mode_i;
            col_q  <= 2'd0;
          end
        end
        RUN: begin
          col_q <= col_q + 2'd1;
          case (col_q)
            2'd0:    res_q[127:96] <= col_out;
            2'd1:    res_q[95:64]  <= col_out;
            2'd2:    res_q[63:32]  <= col_out;
            default: res_q[31:0]   <= col_out;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign state_o = res_q;

endmodule

// File: tb/tb_inv_mixcol_seq.sv
// Directed bench for inv_mixcol_seq: scoreboard of expected results from a
// generic GF(2^8) multiply model, compared when each result is released.
module tb_inv_mixcol_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_i;
  logic         mode_i;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_o;
  logic         busy;

  int           checks = 0;
  int           passes = 0;
  int           releases = 0;
  int           cyc = 0;
  logic [127:0] exp_q[$];

  inv_mixcol_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state_i   (state_i),
    .mode_i    (mode_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_o   (state_o),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] mix_model(input logic [127:0] s, input logic m);
    logic [7:0]   coef[4];
    logic [7:0]   a[4];
    logic [7:0]   b;
    logic [127:0] r;
    r = 128'h0;
    if (m) begin
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    end else begin
      coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    end
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) a[i] = s[127 - 8 * (4 * c + i) -: 8];
      for (int rr = 0; rr < 4; rr++) begin
        b = 8'h00;
        for (int j = 0; j < 4; j++) b = b ^ gf_mul(coef[j], a[(rr + j) % 4]);
        r[127 - 8 * (4 * c + rr) -: 8] = b;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("[TB] check %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checkOutput(tag, {127'b0, obs}, {127'b0, exp});
  endtask

  // One clock edge; a result being released at this edge is scored first.
  task automatic step();
    logic [127:0] e;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkBit("unexpected_output", out_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        checkOutput($sformatf("result%0d", releases), state_o, e);
      end
      releases++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [127:0] s, input logic m);
    bit ok;
    ok       = 1'b0;
    state_i  = s;
    mode_i   = m;
    in_valid = 1'b1;
    for (int k = 0; k < 20 && !ok; k++) begin
      if (in_ready === 1'b1) begin
        exp_q.push_back(mix_model(s, m));
        ok = 1'b1;
      end
      step();
    end
    in_valid = 1'b0;
    checkBit("accepted", ok, 1'b1);
  endtask

  task automatic waitValid(input string tag);
    for (int k = 0; k < 30 && out_valid !== 1'b1; k++) step();
    checkBit(tag, out_valid, 1'b1);
  endtask

  initial begin
    int   acc[2];
    int   n;
    logic seen_valid;
    logic [127:0] fwd_exp;

    rst       = 1'b1;
    in_valid  = 1'b1;
    state_i   = rand128();
    mode_i    = 1'b1;
    out_ready = 1'b0;
    step();
    step();
    checkBit("rst_in_ready", in_ready, 1'b1);
    checkBit("rst_out_valid", out_valid, 1'b0);
    checkBit("rst_busy", busy, 1'b0);
    checkOutput("rst_state_o", state_o, 128'h0);
    rst      = 1'b0;
    in_valid = 1'b0;
    step();
    checkBit("idle_busy", busy, 1'b0);

    $display("[TB] inverse known vector");
    applyStimulus(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkBit($sformatf("lat_busy%0d", i), busy, 1'b1);
      step();
      checkBit($sformatf("lat_out_valid%0d", i), out_valid, 1'b0);
    end
    step();
    checkBit("lat4_out_valid", out_valid, 1'b1);
    checkOutput("inv_known", state_o, 128'hdb135345_f20a225c_01010101_c6c6c6c6);
    out_ready = 1'b1;
    step();
    checkBit("release_out_valid", out_valid, 1'b0);
    checkBit("release_in_ready", in_ready, 1'b1);
    out_ready = 1'b0;

    $display("[TB] forward known vector with backpressure");
    fwd_exp = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
    applyStimulus(128'hdb135345_f20a225c_d4d4d4d5_2d26314c, 1'b1);
    waitValid("fwd_valid");
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      state_i  = rand128();
      mode_i   = i[0];
      step();
      checkOutput($sformatf("bp_state_o%0d", i), state_o, fwd_exp);
      checkBit($sformatf("bp_in_ready%0d", i), in_ready, 1'b0);
      checkBit($sformatf("bp_out_valid%0d", i), out_valid, 1'b1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    checkBit("bp_release_out_valid", out_valid, 1'b0);
    checkBit("bp_release_in_ready", in_ready, 1'b1);
    out_ready = 1'b0;

    $display("[TB] random vectors");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(rand128(), i[0]);
      waitValid($sformatf("rand_valid%0d", i));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end

    $display("[TB] back-to-back");
    out_ready = 1'b1;
    state_i   = rand128();
    mode_i    = 1'b0;
    in_valid  = 1'b1;
    n         = 0;
    acc[0]    = 0;
    acc[1]    = 0;
    for (int k = 0; k < 40 && n < 2; k++) begin
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
        exp_q.push_back(mix_model(state_i, mode_i));
        acc[n] = cyc;
        n++;
      end
      step();
      if (n == 1) begin
        state_i = rand128();
        mode_i  = 1'b1;
      end
      if (n == 2) in_valid = 1'b0;
    end
    checkOutput("b2b_accepts", 128'(n), 128'd2);
    checkOutput("b2b_spacing", 128'(acc[1] - acc[0]), 128'd6);
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) step();
    checkOutput("b2b_drained", 128'(exp_q.size()), 128'd0);

    $display("[TB] mid-operation reset");
    applyStimulus(rand128(), 1'b0);
    step();
    rst = 1'b1;
    step();
    checkBit("abort_in_ready", in_ready, 1'b1);
    checkBit("abort_out_valid", out_valid, 1'b0);
    checkBit("abort_busy", busy, 1'b0);
    checkOutput("abort_state_o", state_o, 128'h0);
    rst = 1'b0;
    exp_q.delete();
    seen_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      seen_valid = seen_valid | out_valid;
    end
    checkBit("abort_no_valid", seen_valid, 1'b0);
    applyStimulus(rand128(), 1'b1);
    waitValid("post_abort_valid");
    step();
    out_ready = 1'b0;
    checkOutput("scoreboard_empty", 128'(exp_q.size()), 128'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/inv_mixcol_seq.md
# inv_mixcol_seq

Column-serial controller for the (Inv)MixColumns stage of the AES-128 datapath. It accepts a 128-bit state over a valid/ready handshake and steps a single shared column unit over columns 0..3, one column per cycle. The column unit is built from the xtime ×02 chain and the derived ×09/×0b/×0d/×0e multipliers. The assembled result is presented on a held output handshake. It sits between the InvShiftRows/InvSubBytes stage and the AddRoundKey stage of the inverse cipher, and can also run forward MixColumns for the encrypt path.

## Interface
- No parameters; widths are fixed by AES-128.
- clk  input  1  rising-edge clock; all state is updated on this edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  state_i and mode_i are valid.
- in_ready  output  1  block can accept a state; high only in IDLE.
- state_i  input  128  input state. Byte k is state_i[127-8k -: 8]; column c is bytes 4c..4c+3, with byte 4c in row 0.
- mode_i  input  1  0 selects InvMixColumns; 1 selects forward MixColumns. Latched on accept.
- out_valid  output  1  state_o holds a complete result; high only in DONE.
- out_ready  input  1  downstream accepts state_o.
- state_o  output  128  result state, same byte and column mapping as state_i.
- busy  output  1  high in RUN or DONE.

## Operation
- FSM states:
  - IDLE: in_ready=1. On in_valid=1 (the accept), latch state_i into the source register and mode_i into the mode register, clear col to 0, and go to RUN.
  - RUN: each cycle, feed source column col through the column unit, write the 32-bit result into state_o column col, and increment col. After writing col=3, go to DONE.
  - DONE: out_valid=1. state_o is held stable. On out_ready=1, go to IDLE.
- col is a 2-bit counter. It wraps 3→0 on the RUN→DONE transition. It holds its value in IDLE and DONE.
- Column unit input is a0..a3 (rows 0..3); output is b0..b3.
  - Inverse mode: b_r = 0e·a_r ^ 0b·a_(r+1) ^ 0d·a_(r+2) ^ 09·a_(r+3), with row indices taken mod 4.
  - Forward mode: b_r = 02·a_r ^ 03·a_(r+1) ^ a_(r+2) ^ a_(r+3).
  - Multiplication is in GF(2^8) with polynomial 0x11b. xtime(x) = (x<<1) ^ (x[7] ? 0x1b : 0), truncated to 8 bits.
  - 09=(((x·2)·2)·2)^x; 0b=((((x·2)·2)^x)·2)^x; 0d=((((x·2)^x)·2)·2)^x; 0e=((((x·2)^x)·2)^x)·2.
  - The column unit is combinational inside one RUN cycle; only the column result is registered.
- Inputs are ignored outside IDLE. Changes to state_i or mode_i during RUN or DONE have no effect.
- In DONE, in_ready stays low even when out_ready=1; there is no same-cycle accept-and-release.
- Columns of state_o not yet written in RUN hold their previous contents. They are not part of a valid result until DONE.

## Timing
- Reset: on the first edge with rst=1:
  - state to IDLE, col to 0, mode register to 0, source register to 0.
  - outputs: state_o=0, in_ready=1, out_valid=0, busy=0.
  - rst has priority over every other event.
- Reset during RUN or DONE aborts the operation. No out_valid is produced for the aborted state.
- Let edge E0 be the edge at which in_valid=1 and in_ready=1 are both sampled.
  - E1..E4 write columns 0..3.
  - out_valid=1 from just after E4.
  - Latency from accept to out_valid is 4 cycles.
- The result is released at the first edge in DONE that samples out_ready=1. out_valid falls and in_ready rises after that edge.
- Minimum spacing between accepts is 6 edges: accept, 4 RUN cycles, release, then the next accept at the following edge.
- out_ready held high continuously gives 1 cycle of out_valid per block.
- Backpressure: DONE holds state_o and out_valid indefinitely while out_ready=0.

## Test plan
- Reset then idle: assert rst for 2 cycles with in_valid=1 → in_ready=1, out_valid=0, busy=0, state_o=0; no accept occurs during reset.
- Inverse known vector: mode_i=0, state_i=8e4da1bc_9fdc589d_01010101_c6c6c6c6 → 4 cycles after accept, out_valid=1 with state_o=db135345_f20a225c_01010101_c6c6c6c6.
- Forward known vector: mode_i=1, state_i=db135345_f20a225c_d4d4d4d5_2d26314c → state_o=8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8.
- Backpressure and input isolation: hold out_ready=0 for 10 cycles in DONE while changing state_i and mode_i → state_o stable, in_ready=0. Then out_ready=1 → release after 1 edge, IDLE on the next cycle.
- Back-to-back: in_valid and out_ready held high with two different states → accepts exactly 6 edges apart, and both results are correct and in order.
- Mid-operation reset: assert rst at E2 of an operation → IDLE and state_o=0 after that edge, no out_valid. A following accept then produces the correct result.
